// File: rtl/pulse_capture_if.sv
// Control/result bundle for pulse_capture: arming, mode, measured pin, timeout limit and the
// valid/ack result handshake with its timeout/overrun pulses.
interface pulse_capture_if #(parameter int COUNTER_SIZE = 32);
  logic                    enable;
  logic [7:0]              captureMode;
  logic                    sig_in;
  logic [COUNTER_SIZE-1:0] timeout_value;
  logic                    ack;
  logic [COUNTER_SIZE-1:0] period;
  logic [COUNTER_SIZE-1:0] width;
  logic                    valid;
  logic                    timeout;
  logic                    overrun;

  modport master (
    output enable, captureMode, sig_in, timeout_value, ack,
    input  period, width, valid, timeout, overrun
  );

  modport slave (
    input  enable, captureMode, sig_in, timeout_value, ack,
    output period, width, valid, timeout, overrun
  );
endinterface

// File: rtl/pulse_capture.sv
// Input capture: period and active width of sig_in in clk cycles; edges act SYNC_STAGES+1 cycles after the pin.
// Result held until ack; a result that lands while one is still unconsumed is dropped and flagged as overrun.
module pulse_capture #(
  parameter int COUNTER_SIZE = 32,
  parameter int SYNC_STAGES  = 2
) (
  input logic            clk,
  input logic            reset,
  pulse_capture_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_EDGE, ACTIVE, REST, DONE} state_t;

  localparam logic [COUNTER_SIZE-1:0] ONE = {{(COUNTER_SIZE-1){1'b0}}, 1'b1};

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    act;
  logic                    act_q;
  logic                    lvl_low;
  logic                    single_shot;
  logic [COUNTER_SIZE-1:0] cnt;
  logic [COUNTER_SIZE-1:0] cnt_inc;
  logic [COUNTER_SIZE-1:0] width_tmp;
  logic [COUNTER_SIZE-1:0] period_q;
  logic [COUNTER_SIZE-1:0] width_q;
  logic                    valid_q;
  logic                    timeout_q;
  logic                    overrun_q;
  logic                    active_edge;
  logic                    inactive_edge;
  logic                    phase_expired;
  logic                    unused_mode;

  assign act           = sync[SYNC_STAGES-1] ^ lvl_low;
  assign active_edge   = act & ~act_q;
  assign inactive_edge = ~act & act_q;
  assign cnt_inc       = cnt + ONE;
  // An all-ones counter is treated as an expired phase even with the timeout disabled.
  assign phase_expired = ((bus.timeout_value != '0) && (cnt_inc == bus.timeout_value)) || (cnt == '1);
  assign unused_mode   = ^bus.captureMode[7:2];

  assign bus.period  = period_q;
  assign bus.width   = width_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;
  assign bus.overrun = overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sync        <= '0;
      act_q       <= 1'b0;
      lvl_low     <= 1'b0;
      single_shot <= 1'b0;
      cnt         <= '0;
      width_tmp   <= '0;
      period_q    <= '0;
      width_q     <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], bus.sig_in};
      act_q     <= act;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      if (bus.ack) valid_q <= 1'b0;

      if (!bus.enable) begin
        state       <= IDLE;
        cnt         <= '0;
        lvl_low     <= bus.captureMode[0];
        single_shot <= bus.captureMode[1];
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT_EDGE;
            cnt   <= '0;
          end
          WAIT_EDGE: begin
            if (active_edge) begin
              state <= ACTIVE;
              cnt   <= '0;
            end
          end
          ACTIVE: begin
            if (inactive_edge) begin
              width_tmp <= cnt_inc;
              cnt       <= cnt_inc;
              state     <= REST;
            end else if (phase_expired) begin
              timeout_q <= 1'b1;
              cnt       <= '0;
              state     <= WAIT_EDGE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          REST: begin
            // The closing active edge also opens the next measurement.
            if (active_edge) begin
              if (!valid_q || bus.ack) begin
                period_q <= cnt_inc;
                width_q  <= width_tmp;
                valid_q  <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              cnt   <= '0;
              state <= single_shot ? DONE : ACTIVE;
            end else if (phase_expired) begin
              timeout_q <= 1'b1;
              cnt       <= '0;
              state     <= WAIT_EDGE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
